// File: rtl/rnn_seq_driver.sv
// rnn_seq_driver: buffers incoming samples and steps an external RNN cell
// through fixed-length sequences, clearing its hidden state before each one.
//
//   state | meaning
//   IDLE  | no sequence in flight, waiting for a buffered sample
//   CLEAR | one-cycle hidden-state clear ahead of the first step
//   RUN   | stepping the RNN once per buffered sample
module rnn_seq_driver #(
    parameter int BW_IN      = 32,
    parameter int BW_OUT     = 32,
    parameter int SEQ_LEN    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [BW_IN-1:0]    s_data,
    output logic signed [BW_IN-1:0]    rnn_in,
    output logic                       rnn_step,
    output logic                       rnn_clear,
    input  logic signed [BW_OUT-1:0]   rnn_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [BW_OUT-1:0]   m_data,
    output logic                       m_last,
    output logic [$clog2(SEQ_LEN)-1:0] seq_idx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(SEQ_LEN);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t                  state, state_next;
    logic signed [BW_IN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    push, pop, empty, seq_end;

    assign empty   = (count == '0);
    assign s_ready = (count < CW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = rnn_step;
    assign rnn_in  = empty ? '0 : mem[rd_ptr];
    assign seq_end = (seq_idx == IW'(SEQ_LEN - 1));

    // Sample storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and step/clear strobes. After a sequence's final step we go
    // straight to CLEAR when a sample is still buffered (or arriving), so
    // back-to-back sequences are separated by exactly one clear cycle.
    always_comb begin
        state_next = state;
        rnn_clear  = 1'b0;
        rnn_step   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_next = CLEAR;
            end
            CLEAR: begin
                rnn_clear  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                rnn_step = !empty && (!m_valid || m_ready);
                if (rnn_step && seq_end) begin
                    state_next = ((count > CW'(1)) || push) ? CLEAR : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result register and step index; results hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            seq_idx <= '0;
        end else if (rnn_step) begin
            m_valid <= 1'b1;
            m_data  <= rnn_out;
            m_last  <= seq_end;
            seq_idx <= seq_end ? '0 : seq_idx + IW'(1);
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rnn_seq_driver.sv
// Testbench for rnn_seq_driver: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_rnn_seq_driver;

    localparam int BW_IN  = 16;
    localparam int BW_OUT = 24;
    localparam int SL     = 4;
    localparam int FD     = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic signed [BW_IN-1:0]  s_data = '0;
    logic signed [BW_IN-1:0]  rnn_in;
    logic                     rnn_step, rnn_clear;
    logic signed [BW_OUT-1:0] rnn_out;
    logic signed [BW_OUT-1:0] rnn_ext;
    logic                     m_valid;
    logic                     m_ready = 1'b1;
    logic signed [BW_OUT-1:0] m_data;
    logic                     m_last;
    logic [1:0]               seq_idx;

    rnn_seq_driver #(.BW_IN(BW_IN), .BW_OUT(BW_OUT), .SEQ_LEN(SL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rnn_in(rnn_in), .rnn_step(rnn_step), .rnn_clear(rnn_clear), .rnn_out(rnn_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .seq_idx(seq_idx)
    );

    // RNN stub: output is twice the presented sample.
    assign rnn_ext = rnn_in;
    assign rnn_out = rnn_ext + rnn_ext;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint exp_out(input longint x);
        logic signed [BW_OUT-1:0] r;
        r = BW_OUT'(x * 2);
        return longint'(r);
    endfunction

    // Reference model: accepted samples in order, and expected results in order.
    typedef struct { longint d; bit last; } res_t;
    longint in_q[$];
    res_t   res_q[$];
    int     step_cnt = 0;
    int     clr_since = 0;
    bit     prev_clear = 0, prev_last_step = 0, prev_stall = 0;
    logic signed [BW_OUT-1:0] prev_data = '0;
    logic   prev_mlast = 1'b0;
    int     step_cycs[$], clr_cycs[$], acc_cycs[$];
    int     occ;
    bit     ok_out;
    res_t   r;

    always @(negedge clk) begin
        if (rst) begin
            in_q.delete();
            res_q.delete();
            step_cnt       = 0;
            clr_since      = 0;
            prev_clear     = 0;
            prev_last_step = 0;
            prev_stall     = 0;
        end else begin
            occ    = in_q.size();
            ok_out = !m_valid || m_ready;
            check_val("clear_with_step", rnn_clear && rnn_step, 0);
            check_val("s_ready", s_ready, occ < FD);
            if (occ == 0) check_val("rnn_in_empty", rnn_in, 0);
            if (prev_stall) begin
                check_val("hold_valid", m_valid, 1);
                check_val("hold_data", m_data, prev_data);
                check_val("hold_last", m_last, prev_mlast);
            end
            if (m_valid && !m_ready) check_val("step_in_stall", rnn_step, 0);
            if (occ > 0 && ok_out && ((step_cnt % SL != 0) || prev_clear))
                check_val("step_due", rnn_step, 1);
            if (prev_last_step && occ > 0) check_val("clear_due", rnn_clear, 1);

            if (m_valid && m_ready) begin
                check_val("result_avail", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    check_val("m_data", m_data, r.d);
                    check_val("m_last", m_last, r.last);
                end
            end

            if (rnn_clear) begin
                clr_since++;
                clr_cycs.push_back(cyc);
            end
            prev_last_step = 0;
            if (rnn_step) begin
                check_val("step_nonempty", occ > 0, 1);
                if (occ > 0) begin
                    check_val("rnn_in", rnn_in, in_q[0]);
                    check_val("seq_idx", seq_idx, step_cnt % SL);
                    check_val("clears_before", clr_since, (step_cnt % SL == 0) ? 1 : 0);
                    r.d    = exp_out(in_q[0]);
                    r.last = (step_cnt % SL == SL - 1);
                    res_q.push_back(r);
                    void'(in_q.pop_front());
                    prev_last_step = r.last;
                    step_cnt++;
                end
                clr_since = 0;
                step_cycs.push_back(cyc);
            end

            if (s_valid && s_ready) begin
                in_q.push_back(longint'(s_data));
                acc_cycs.push_back(cyc);
            end
            prev_clear = rnn_clear;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_mlast = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic send(input longint x);
        bit done;
        done    = 0;
        s_valid = 1'b1;
        s_data  = BW_IN'(x);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                tick();
                done = 1;
            end
        end
        s_valid = 1'b0;
        check_val("send_timeout", done, 1);
    endtask

    task automatic clr_logs();
        step_cycs.delete();
        clr_cycs.delete();
        acc_cycs.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit done;

        // Reset state
        m_ready = 1'b1;
        do_reset(2);
        @(negedge clk);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_s_ready", s_ready, 1);
        check_val("rst_step", rnn_step, 0);
        check_val("rst_clear", rnn_clear, 0);
        check_val("rst_seq_idx", seq_idx, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_m_last", m_last, 0);
        tick();

        // Streaming: 1,2,3,4 back-to-back
        clr_logs();
        for (int i = 1; i <= 4; i++) send(i);
        repeat (8) tick();
        check_val("stream_steps", step_cycs.size(), 4);
        check_val("stream_clears", clr_cycs.size(), 1);
        if (step_cycs.size() == 4 && clr_cycs.size() == 1) begin
            check_val("stream_latency", step_cycs[0], acc_cycs[0] + 3);
            check_val("stream_clear_cyc", clr_cycs[0], acc_cycs[0] + 2);
            for (int i = 1; i < 4; i++) check_val("stream_rate", step_cycs[i], step_cycs[i-1] + 1);
        end

        // Backpressure: consumer stalled from the first result
        clr_logs();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i);
        repeat (6) tick();
        @(negedge clk);
        check_val("bp_steps", step_cycs.size(), 1);
        check_val("bp_valid", m_valid, 1);
        check_val("bp_data", m_data, 2);
        tick();
        m_ready = 1'b1;
        repeat (6) tick();
        check_val("bp_steps_after", step_cycs.size(), 4);
        if (step_cycs.size() == 4)
            for (int i = 2; i < 4; i++) check_val("bp_rate", step_cycs[i], step_cycs[i-1] + 1);

        // Full FIFO: 6 offered with the consumer stalled
        clr_logs();
        m_ready = 1'b0;
        for (int i = 10; i < 15; i++) send(i);
        s_valid = 1'b1;
        s_data  = 16'sd15;
        repeat (5) tick();
        @(negedge clk);
        check_val("full_accepted", acc_cycs.size(), 5);
        check_val("full_s_ready", s_ready, 0);
        check_val("full_steps", step_cycs.size(), 1);
        tick();
        m_ready = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                tick();
                done = 1;
            end
        end
        s_valid = 1'b0;
        check_val("full_sixth_taken", done, 1);
        repeat (10) tick();
        check_val("full_accepted_all", acc_cycs.size(), 6);
        check_val("full_steps_all", step_cycs.size(), 6);
        @(negedge clk);
        check_val("mid_seq_idx", seq_idx, 2);
        tick();

        // Mid-sequence reset
        do_reset(1);
        @(negedge clk);
        check_val("mrst_seq_idx", seq_idx, 0);
        check_val("mrst_m_valid", m_valid, 0);
        check_val("mrst_s_ready", s_ready, 1);
        check_val("mrst_rnn_in", rnn_in, 0);
        tick();
        clr_logs();
        send(-7);
        repeat (6) tick();
        check_val("mrst_steps", step_cycs.size(), 1);
        check_val("mrst_clears", clr_cycs.size(), 1);
        if (step_cycs.size() == 1 && clr_cycs.size() == 1) begin
            check_val("mrst_clear_first", clr_cycs[0], step_cycs[0] - 1);
            check_val("mrst_latency", step_cycs[0], acc_cycs[0] + 3);
        end

        // Two sequences back-to-back
        do_reset(1);
        clr_logs();
        for (int i = 0; i < 8; i++) send(100 + 3 * i);
        repeat (12) tick();
        check_val("two_steps", step_cycs.size(), 8);
        check_val("two_clears", clr_cycs.size(), 2);
        if (step_cycs.size() == 8 && clr_cycs.size() == 2) begin
            check_val("two_clear_gap", clr_cycs[1], step_cycs[3] + 1);
            check_val("two_step5", step_cycs[4], step_cycs[3] + 2);
            for (int i = 5; i < 8; i++) check_val("two_rate", step_cycs[i], step_cycs[i-1] + 1);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = 16'($urandom);
            m_ready = ($urandom % 3) != 0;
            rst     = ($urandom % 400) == 0;
            tick();
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check_val("drain_inputs", in_q.size(), 0);
        check_val("drain_results", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
